// File: rtl/ddr_app_responder_if.sv
// DDR3 controller application-side bus.
// master = user logic driving commands, slave = responder/controller.
interface ddr_app_responder_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 64
) ();
    logic [ADDR_WIDTH-1:0]   app_addr;
    logic [2:0]              app_cmd;
    logic                    app_en;
    logic                    app_rdy;
    logic [DATA_WIDTH*8-1:0] app_wdf_data;
    logic [DATA_WIDTH-1:0]   app_wdf_mask;
    logic                    app_wdf_wren;
    logic                    app_wdf_end;
    logic                    app_wdf_rdy;
    logic [DATA_WIDTH*8-1:0] app_rd_data;
    logic                    app_rd_data_valid;
    logic                    app_rd_data_end;
    logic                    init_calib_complete;

    modport master (
        output app_addr, app_cmd, app_en,
        output app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy,
        input  app_rd_data, app_rd_data_valid, app_rd_data_end,
        input  init_calib_complete
    );

    modport slave (
        input  app_addr, app_cmd, app_en,
        input  app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy,
        output app_rd_data, app_rd_data_valid, app_rd_data_end,
        output init_calib_complete
    );
endinterface

// File: rtl/ddr_app_responder.sv
// Stand-in for MIG controller + DDR3: byte-writable on-chip RAM behind
// the app_* handshake, with calibration delay and refresh stalls.
module ddr_app_responder #(
    parameter int ADDR_WIDTH   = 28,
    parameter int DATA_WIDTH   = 64,
    parameter int MEM_AW       = 10,
    parameter int RD_LATENCY   = 4,
    parameter int CALIB_CYCLES = 64,
    parameter int REF_INTERVAL = 512,
    parameter int REF_STALL    = 8
) (
    input  logic                 ui_clk,
    input  logic                 rst_n,
    ddr_app_responder_if.slave   app,
    output logic                 proto_err
);
    localparam int WB = DATA_WIDTH * 8;
    localparam int QW = WB + DATA_WIDTH;
    localparam int CW = $clog2(CALIB_CYCLES + 1);
    localparam int RW = $clog2(REF_INTERVAL);
    localparam logic [CW-1:0] CAL_LAST = CW'(CALIB_CYCLES - 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REF_INTERVAL - 1);
    localparam logic [RW-1:0] REF_STL  = RW'(REF_STALL);
    localparam logic [2:0]    CMD_WR   = 3'b000;
    localparam logic [2:0]    CMD_RD   = 3'b001;

    logic              calib;
    logic [CW-1:0]     cal_cnt;
    logic [RW-1:0]     ref_cnt;
    logic              stall;
    logic [2:0]        aq_cnt, dq_cnt;
    logic [1:0]        aq_wp, aq_rp, dq_wp, dq_rp;
    logic [MEM_AW-1:0] aq [4];
    logic [QW-1:0]     dq [4];
    logic [WB-1:0]     mem [0:(1<<MEM_AW)-1];
    logic [MEM_AW-1:0] beat;
    logic              cmd_acc, wr_acc, rd_acc, bad_acc;
    logic              dat_acc, pop, perr_ev;
    logic              addr_unused;

    logic [RD_LATENCY-1:0] pv;
    logic [WB-1:0]         pd [RD_LATENCY];

    assign beat        = app.app_addr[MEM_AW+2:3];
    assign addr_unused = ^{app.app_addr[ADDR_WIDTH-1:MEM_AW+3],
                           app.app_addr[2:0]};

    assign stall = calib && (ref_cnt < REF_STL);

    // Reads wait for an empty write-address queue: read-after-write order.
    assign app.app_rdy = calib & ~stall & ~aq_cnt[2] &
                         ((app.app_cmd != CMD_RD) | (aq_cnt == 3'd0));
    assign app.app_wdf_rdy         = calib & ~dq_cnt[2];
    assign app.init_calib_complete = calib;

    assign cmd_acc = app.app_en & app.app_rdy;
    assign wr_acc  = cmd_acc & (app.app_cmd == CMD_WR);
    assign rd_acc  = cmd_acc & (app.app_cmd == CMD_RD);
    assign bad_acc = cmd_acc & ~wr_acc & ~rd_acc;
    assign dat_acc = app.app_wdf_wren & app.app_wdf_rdy;
    assign pop     = (aq_cnt != 3'd0) & (dq_cnt != 3'd0);
    assign perr_ev = bad_acc | (app.app_wdf_wren != app.app_wdf_end) |
                     (~calib & (app.app_en | app.app_wdf_wren));

    // Calibration/refresh timers, queue pointers and sticky error flag.
    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            calib     <= 1'b0;
            cal_cnt   <= '0;
            ref_cnt   <= '0;
            aq_cnt    <= '0;
            dq_cnt    <= '0;
            aq_wp     <= '0;
            aq_rp     <= '0;
            dq_wp     <= '0;
            dq_rp     <= '0;
            proto_err <= 1'b0;
        end else begin
            if (!calib) begin
                cal_cnt <= cal_cnt + 1'b1;
                if (cal_cnt == CAL_LAST) calib <= 1'b1;
            end else begin
                ref_cnt <= (ref_cnt == REF_LAST) ? '0 : ref_cnt + 1'b1;
            end
            if (wr_acc)  aq_wp <= aq_wp + 1'b1;
            if (dat_acc) dq_wp <= dq_wp + 1'b1;
            if (pop) begin
                aq_rp <= aq_rp + 1'b1;
                dq_rp <= dq_rp + 1'b1;
            end
            aq_cnt <= aq_cnt + {2'b0, wr_acc} - {2'b0, pop};
            dq_cnt <= dq_cnt + {2'b0, dat_acc} - {2'b0, pop};
            if (perr_ev) proto_err <= 1'b1;
        end
    end

    // Queue storage and masked RAM commit; contents survive reset.
    always_ff @(posedge ui_clk) begin
        if (wr_acc)  aq[aq_wp] <= beat;
        if (dat_acc) dq[dq_wp] <= {app.app_wdf_data, app.app_wdf_mask};
        if (pop) begin
            for (int b = 0; b < DATA_WIDTH; b++) begin
                if (!dq[dq_rp][b])
                    mem[aq[aq_rp]][b*8 +: 8] <=
                        dq[dq_rp][DATA_WIDTH + b*8 +: 8];
            end
        end
    end

    // Fixed-latency read shift register; never stalls, cleared by reset.
    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            pv                    <= '0;
            app.app_rd_data_valid <= 1'b0;
            app.app_rd_data_end   <= 1'b0;
            app.app_rd_data       <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pd[i] <= '0;
        end else begin
            pv    <= {pv[RD_LATENCY-2:0], rd_acc};
            pd[0] <= mem[beat];
            for (int i = 1; i < RD_LATENCY; i++) pd[i] <= pd[i-1];
            app.app_rd_data_valid <= pv[RD_LATENCY-1];
            app.app_rd_data_end   <= pv[RD_LATENCY-1];
            if (pv[RD_LATENCY-1]) app.app_rd_data <= pd[RD_LATENCY-1];
        end
    end
endmodule

// File: doc/ddr_app_responder.md
Name: ddr_app_responder

Overview:
- Synthesizable responder for the DDR3 controller application interface (app_cmd/app_en/app_wdf_*/app_rd_*), backed by on-chip byte-writable RAM.
- Replaces the memory controller plus DDR3 device during board bring-up and simulation, so the DDR write/read control logic can run without physical memory.
- Reproduces the controller-side handshakes: calibration delay, app_rdy/app_wdf_rdy backpressure, periodic refresh stalls, in-order read return.

Parameters:
- ADDR_WIDTH, 28, width of app_addr.
- DATA_WIDTH, 64, DQ width; app data bus is DATA_WIDTH*8 = 512 bits and mask is DATA_WIDTH bits.
- MEM_AW, 10, log2 of RAM depth in 512-bit beats (1024 beats).
- RD_LATENCY, 4, cycles from read command acceptance to app_rd_data_valid; legal range 2..15.
- CALIB_CYCLES, 64, cycles after reset release before init_calib_complete rises.
- REF_INTERVAL, 512, period of the refresh stall in cycles.
- REF_STALL, 8, cycles app_rdy is forced low per refresh.

Ports:
- ui_clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- app_addr  in  ADDR_WIDTH  command address in 8-byte units; beat index = app_addr[MEM_AW+2:3]; upper bits ignored (aliasing).
- app_cmd  in  3  3'b000 = write, 3'b001 = read, others illegal.
- app_en  in  1  command valid.
- app_rdy  out  1  command ready; a command is accepted when app_en & app_rdy.
- app_wdf_data  in  DATA_WIDTH*8  write data beat.
- app_wdf_mask  in  DATA_WIDTH  byte mask; 1 = byte not written.
- app_wdf_wren  in  1  write data valid.
- app_wdf_end  in  1  last beat; must equal app_wdf_wren (one beat per burst).
- app_wdf_rdy  out  1  write data ready; a beat is accepted when app_wdf_wren & app_wdf_rdy.
- app_rd_data  out  DATA_WIDTH*8  read data.
- app_rd_data_valid  out  1  read data valid.
- app_rd_data_end  out  1  equals app_rd_data_valid.
- init_calib_complete  out  1  responder is ready for traffic.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0; app_rd_data = 0.
  - Both queues empty; read pipeline cleared; counters zeroed.
  - RAM contents are not cleared.
- Calibration:
  - A counter runs from reset release; init_calib_complete rises on the cycle after CALIB_CYCLES ui_clk edges and stays high.
  - app_rdy and app_wdf_rdy are 0 while init_calib_complete is 0.
- Refresh:
  - A free-running counter starts at calibration done.
  - app_rdy is forced 0 for REF_STALL cycles at the start of each REF_INTERVAL period.
  - app_wdf_rdy is unaffected by refresh.
- Write path:
  - Accepted write command pushes its beat index into a 4-deep address queue.
  - Accepted write data beat pushes {data, mask} into a 4-deep data queue.
  - Data may arrive before, with, or after its command.
  - When both queues are non-empty, the heads are popped together and written to RAM, honouring the mask, in the same cycle (1 pop per cycle).
  - app_wdf_rdy = calibrated & data queue not full.
- Read path:
  - Accepted read reads RAM at its beat index.
  - app_rd_data_valid/app_rd_data_end are asserted exactly RD_LATENCY cycles after the acceptance edge, for one cycle per read.
  - Reads return in acceptance order; back-to-back reads stream back-to-back.
  - The read pipeline is a shift register of depth RD_LATENCY, so it never stalls; the consumer cannot backpressure.
- app_rdy rule: calibrated & not refresh-stall & address queue not full & (for reads) address queue empty.
  - The read condition is evaluated against the current app_cmd, so app_rdy may depend combinationally on app_cmd.
  - Consequence: a read is held off until all earlier writes have committed (read-after-write ordering guaranteed).
- Simultaneous events:
  - Queue push and pop in the same cycle keeps the occupancy unchanged.
  - A full queue that pops accepts no new entry that cycle; ready is computed from registered occupancy.
- proto_err is set (sticky until reset) on any of:
  - accepted command with an illegal app_cmd (command is dropped);
  - app_wdf_wren != app_wdf_end;
  - app_en or app_wdf_wren high before init_calib_complete.
- Reset mid-operation:
  - Pending queue entries and in-flight reads are discarded.
  - No app_rd_data_valid is emitted after reset.
  - Calibration restarts.

Test Plan:
- Reset release, CALIB_CYCLES=64 -> init_calib_complete rises after 64 cycles; app_rdy/app_wdf_rdy are 0 until then; a write strobe at cycle 10 sets proto_err.
- Write 0xA5-pattern at app_addr 0x40, then read 0x40, RD_LATENCY=4 -> app_rd_data_valid and app_rd_data_end high exactly 4 cycles after read acceptance with 0xA5 pattern; beat index 8.
- Data-before-command: 3 data beats, then 3 write commands to 0x0/0x8/0x10, then 3 back-to-back reads -> 3 consecutive valid beats in order with matching data.
- Mask: write all-0xFF, then write 0x00 with mask 64'hFFFF_FFFF_FFFF_FFFE -> readback byte0 = 0x00, other bytes = 0xFF.
- Backpressure: 5 write commands with no data -> app_rdy low after 4th; read command is held while queue non-empty; refresh window drops app_rdy for 8 cycles every 512.
- Assert rst_n low with 2 reads in flight -> no valid pulse afterward; all outputs 0; calibration restarts.
